// File: rtl/double_buffer_ctrl.sv
// Ping-pong frame buffer controller: one bank is filled by the write stream while
// the other is displayed, with banks swapped only at a reader frame boundary.
module double_buffer_ctrl #(
  parameter int FRAME_WORDS = 256,
  parameter int DATA_WIDTH  = 32,
  localparam int IDX_W      = $clog2(FRAME_WORDS),
  localparam int ADDR_W     = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_sof,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic                  rd_frame_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  frame_avail,
  output logic [7:0]            short_frames,
  output logic                  bram_cea,
  output logic [ADDR_W-1:0]     bram_ada,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_ceb,
  output logic                  bram_oce,
  output logic [ADDR_W-1:0]     bram_adb,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  bram_reseta,
  output logic                  bram_resetb
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_FULL} wstate_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  wstate_t                 r_state;
  logic [IDX_W-1:0]        r_wr_idx;
  logic                    r_wbank;
  logic                    r_rd_busy;
  logic                    r_frame_avail;
  logic [7:0]              r_short_frames;
  logic                    r_cea_p1;
  logic [ADDR_W-1:0]       r_ada_p1;
  logic [DATA_WIDTH-1:0]   r_din_p1;
  logic                    r_ceb_p1;
  logic [ADDR_W-1:0]       r_adb_p1;
  logic                    r_oce_p2;
  logic                    r_vld_p3;

  logic w_wr_ready;
  logic w_accept;
  logic w_swap;

  assign w_wr_ready = (r_state != W_FULL);
  assign w_accept   = wr_valid & w_wr_ready;
  // A same-cycle rd_req defers the swap so a read never lands on the bank being handed over.
  assign w_swap     = (r_state == W_FULL) & (~r_rd_busy | rd_frame_done) & ~rd_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= W_IDLE;
      r_wr_idx       <= '0;
      r_wbank        <= 1'b0;
      r_rd_busy      <= 1'b0;
      r_frame_avail  <= 1'b0;
      r_short_frames <= 8'd0;
      r_cea_p1       <= 1'b0;
      r_ada_p1       <= '0;
      r_din_p1       <= '0;
      r_ceb_p1       <= 1'b0;
      r_adb_p1       <= '0;
      r_oce_p2       <= 1'b0;
      r_vld_p3       <= 1'b0;
    end else begin
      r_cea_p1 <= 1'b0;

      if (rd_req)
        r_rd_busy <= 1'b1;
      else if (rd_frame_done)
        r_rd_busy <= 1'b0;

      case (r_state)
        W_IDLE: begin
          if (w_accept && wr_sof) begin
            r_cea_p1 <= 1'b1;
            r_ada_p1 <= {r_wbank, IDX_ZERO};
            r_din_p1 <= wr_data;
            r_wr_idx <= IDX_ONE;
            r_state  <= W_FILL;
          end
        end
        W_FILL: begin
          if (w_accept) begin
            r_cea_p1 <= 1'b1;
            r_din_p1 <= wr_data;
            if (wr_sof) begin
              r_ada_p1       <= {r_wbank, IDX_ZERO};
              r_wr_idx       <= IDX_ONE;
              r_short_frames <= sat_inc8(r_short_frames);
            end else begin
              r_ada_p1 <= {r_wbank, r_wr_idx};
              if (r_wr_idx == LAST_IDX) begin
                r_wr_idx <= '0;
                r_state  <= W_FULL;
              end else begin
                r_wr_idx <= r_wr_idx + IDX_ONE;
              end
            end
          end
        end
        W_FULL: begin
          if (w_swap) begin
            r_wbank       <= ~r_wbank;
            r_frame_avail <= 1'b1;
            r_state       <= W_IDLE;
          end
        end
        default: r_state <= W_IDLE;
      endcase

      // p1: read port enable/address, bank taken from the request cycle
      r_ceb_p1 <= rd_req;
      if (rd_req)
        r_adb_p1 <= {~r_wbank, rd_idx};
      // p2: BRAM output register enable
      r_oce_p2 <= r_ceb_p1;
      // p3: data presented from the BRAM output register
      r_vld_p3 <= r_oce_p2;
    end
  end

  assign wr_ready      = w_wr_ready;
  assign frame_avail   = r_frame_avail;
  assign short_frames  = r_short_frames;
  assign bram_cea      = r_cea_p1;
  assign bram_ada      = r_ada_p1;
  assign bram_din      = r_din_p1;
  assign bram_ceb      = r_ceb_p1;
  assign bram_adb      = r_adb_p1;
  assign bram_oce      = r_oce_p2;
  assign rd_data_valid = r_vld_p3;
  assign rd_data       = bram_dout;
  assign bram_reseta   = reset;
  assign bram_resetb   = reset;

endmodule

// File: tb/tb_double_buffer_ctrl.sv
// Directed bench for double_buffer_ctrl with FRAME_WORDS=4: a two-bank BRAM model
// with output register, and a queue of expected read words checked on rd_data_valid.
module tb_double_buffer_ctrl;

  localparam int FW = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          wr_sof, wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_req, rd_frame_done;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid, frame_avail;
  logic [7:0]    short_frames;
  logic          bram_cea, bram_ceb, bram_oce;
  logic [AW-1:0] bram_ada, bram_adb;
  logic [DW-1:0] bram_din, bram_dout;
  logic          bram_reseta, bram_resetb;

  double_buffer_ctrl #(.FRAME_WORDS(FW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_frame_done(rd_frame_done),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .frame_avail(frame_avail), .short_frames(short_frames),
    .bram_cea(bram_cea), .bram_ada(bram_ada), .bram_din(bram_din),
    .bram_ceb(bram_ceb), .bram_oce(bram_oce), .bram_adb(bram_adb),
    .bram_dout(bram_dout), .bram_reseta(bram_reseta), .bram_resetb(bram_resetb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // True dual-port BRAM with read latch (ceb) followed by output register (oce).
  logic [DW-1:0] mem [0:(2*FW)-1];
  logic [DW-1:0] lat;
  always @(posedge clk) begin
    if (bram_cea) mem[bram_ada] <= bram_din;
    if (bram_ceb) lat <= mem[bram_adb];
    if (bram_oce) bram_dout <= lat;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] q_d[$];
  int            q_c[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_data_valid === 1'b1) begin
      if (q_d.size() == 0) begin
        chk("rd_spurious_valid", 32'd1, 32'd0);
      end else begin
        logic [DW-1:0] ed;
        int ec;
        ed = q_d.pop_front();
        ec = q_c.pop_front();
        chk("rd_data", rd_data, ed);
        chk("rd_latency_cycle", cyc, ec);
      end
    end
  end

  task automatic write_word(input logic sof, input logic [31:0] d, input int ada_exp);
    wr_valid = 1'b1;
    wr_sof   = sof;
    wr_data  = d;
    @(posedge clk); @(negedge clk);
    chk("wr_cea", bram_cea, 32'd1);
    chk("wr_ada", bram_ada, ada_exp);
    chk("wr_din", bram_din, d);
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic read_word(input int idx, input logic [31:0] d_exp, input int adb_exp);
    rd_req = 1'b1;
    rd_idx = IW'(idx);
    q_d.push_back(d_exp);
    q_c.push_back(cyc + 3);
    @(posedge clk); @(negedge clk);
    chk("rd_ceb", bram_ceb, 32'd1);
    chk("rd_adb", bram_adb, adb_exp);
    rd_req = 1'b0;
  endtask

  task automatic pulse_done();
    rd_frame_done = 1'b1;
    @(posedge clk); @(negedge clk);
    rd_frame_done = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_wr_ready", wr_ready, 32'd1);
    chk("rst_frame_avail", frame_avail, 32'd0);
    chk("rst_short_frames", short_frames, 32'd0);
    chk("rst_cea", bram_cea, 32'd0);
    chk("rst_ada", bram_ada, 32'd0);
    chk("rst_din", bram_din, 32'd0);
    chk("rst_ceb", bram_ceb, 32'd0);
    chk("rst_oce", bram_oce, 32'd0);
    chk("rst_adb", bram_adb, 32'd0);
    chk("rst_valid", rd_data_valid, 32'd0);
    chk("rst_reseta", bram_reseta, 32'd1);
    chk("rst_resetb", bram_resetb, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_sof = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_req = 1'b0; rd_idx = '0; rd_frame_done = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    // First frame into bank 0, swap on the cycle after the last word.
    for (int i = 0; i < FW; i++) write_word(i == 0, 32'hA0 + i, i);
    chk("full_wr_ready", wr_ready, 32'd0);
    chk("pre_swap_avail", frame_avail, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("post_swap_wr_ready", wr_ready, 32'd1);
    chk("post_swap_avail", frame_avail, 32'd1);

    // Back-to-back reads from display bank 0.
    for (int i = 0; i < FW; i++) read_word(i, 32'hA0 + i, i);
    repeat (4) @(posedge clk);
    @(negedge clk);

    // Second frame into bank 1 while the reader is busy: writer must stall.
    for (int i = 0; i < FW; i++) write_word(i == 0, 32'hB0 + i, 4 + i);
    wr_valid = 1'b1; wr_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      chk("busy_wr_ready", wr_ready, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("busy_no_write", bram_cea, 32'd0);
    end
    wr_valid = 1'b0;
    // Frame done together with a request defers the swap.
    rd_frame_done = 1'b1; rd_req = 1'b1; rd_idx = 2'd1;
    q_d.push_back(32'hA1); q_c.push_back(cyc + 3);
    @(posedge clk); @(negedge clk);
    rd_frame_done = 1'b0; rd_req = 1'b0;
    chk("defer_adb", bram_adb, 32'd1);
    chk("defer_wr_ready", wr_ready, 32'd0);
    pulse_done();
    chk("swap2_wr_ready", wr_ready, 32'd1);
    for (int i = 0; i < FW; i++) read_word(i, 32'hB0 + i, 4 + i);
    pulse_done();
    repeat (4) @(posedge clk);
    @(negedge clk);

    // Aborted frame then a full one into bank 0.
    write_word(1'b1, 32'hC0, 0);
    write_word(1'b0, 32'hC1, 1);
    write_word(1'b1, 32'hD0, 0);
    chk("short_one", short_frames, 32'd1);
    for (int i = 1; i < FW; i++) write_word(1'b0, 32'hD0 + i, i);
    chk("full2_wr_ready", wr_ready, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("swap3_wr_ready", wr_ready, 32'd1);
    for (int i = 0; i < FW; i++) read_word(i, 32'hD0 + i, i);
    pulse_done();
    repeat (4) @(posedge clk);
    @(negedge clk);

    // Words without sof in W_IDLE are discarded.
    wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_discard_cea", bram_cea, 32'd0);
    end
    // 300 sof-started frames, each aborted after one word: counter saturates.
    for (int i = 1; i <= 300; i++) begin
      wr_valid = 1'b1; wr_sof = 1'b1; wr_data = i;
      @(posedge clk); @(negedge clk);
      wr_sof = 1'b0; wr_data = ~i;
      @(posedge clk); @(negedge clk);
      if (i == 100) chk("short_mid", short_frames, 32'd100);
    end
    wr_valid = 1'b0;
    chk("short_sat", short_frames, 32'd255);

    // Reset mid-fill with a read in flight.
    rd_req = 1'b1; rd_idx = 2'd0;
    @(posedge clk); @(negedge clk);
    rd_req = 1'b0;
    chk("inflight_ceb", bram_ceb, 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("post_rst_no_valid", rd_data_valid, 32'd0);
    end
    wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 32'h77;
    @(posedge clk); @(negedge clk);
    chk("post_rst_idle_discard", bram_cea, 32'd0);
    wr_valid = 1'b0;
    for (int i = 0; i < FW; i++) write_word(i == 0, 32'hE0 + i, i);
    @(posedge clk); @(negedge clk);
    chk("post_rst_avail", frame_avail, 32'd1);
    read_word(2, 32'hE2, 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", q_d.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
